// File: rtl/fetch_prefetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_queue_pkg
//   Shared constants and the fetch-entry layout for the RV32I prefetch
//   queue.
//
//   Contents:
//     DEF_XLEN / DEF_DEPTH / DEF_TAG_W / DEF_RESET_PC : default parameters
//     PC_STEP       : byte distance between sequential instructions
//     entry_width() : packed width of one queue entry
//     fetch_entry_t : entry layout at the default widths
//
//   An entry is packed MSB-first as {instr, pc, tag}. The parametrised top
//   builds the same layout by concatenation. The next PC is not stored,
//   because it is always pc + PC_STEP.
// ----------------------------------------------------------------------------
package fetch_prefetch_queue_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam int          DEF_TAG_W    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

    // Width of one packed {instr, pc, tag} entry.
    function automatic int entry_width(input int xlen, input int tag_w);
        return 2 * xlen + tag_w;
    endfunction

    typedef struct packed {
        logic [DEF_XLEN-1:0]  instr;
        logic [DEF_XLEN-1:0]  pc;
        logic [DEF_TAG_W-1:0] tag;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of DEPTH entries (a power of two) with flush. The
//   read and write pointers carry one extra MSB, so full and empty can be
//   told apart. The occupancy is the difference of the two pointers.
//
//   The head is kept in its own register (head_q), so the consumer sees a
//   registered output. That register is loaded one edge ahead:
//     - When the FIFO is empty, or holds one entry that is being popped,
//       the head register takes the incoming push data.
//     - On a pop from a deeper FIFO, it takes the entry behind the
//       current head.
//     - Otherwise it holds its value.
//   This gives one-cycle latency from push to head, with no bypass path.
//
//   Ports:
//     i_clk, i_rst : clock and synchronous active-high reset
//     i_push       : write i_data into the tail
//     i_data       : entry to write
//     i_pop        : remove the head (ignored when empty)
//     i_flush      : empty the FIFO; has priority over push and pop
//     o_head       : current head entry (registered)
//     o_count      : number of buffered entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [AW-1:0]    rd_next_idx;
    logic             do_push;
    logic             do_pop;

    assign o_count     = wr_ptr_q - rd_ptr_q;
    assign o_head      = head_q;
    assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);

    // A push into a full FIFO is accepted only when a pop frees a slot in
    // the same cycle. The credit logic upstream never asks for more than
    // that, so this guard only protects against misuse.
    assign do_pop  = i_pop && (o_count != '0) && !i_flush;
    assign do_push = i_push && !i_flush && ((o_count != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
            // Decide what the head register shows after this edge.
            if ((o_count == '0) || (do_pop && (o_count == CW'(1)))) begin
                head_d = i_data;
            end else if (do_pop) begin
                head_d = mem_q[rd_next_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // The storage array is never reset. Its contents are only observed
    // through head_q once a push has written them.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_queue
//   RV32I fetch stage. It issues sequential instruction-memory requests
//   ahead of consumption and buffers the returned instructions, each with
//   its PC and pipeline tag. The decoder drains the buffer through a
//   valid/ready handshake. A jump from retire does four things:
//     - flushes the buffer,
//     - marks all in-flight responses for discard,
//     - redirects both PCs,
//     - bumps the tag.
//
//   Ports:
//     i_clk, i_rst      : clock, synchronous active-high reset
//     i_jump            : redirect from retire
//     i_jump_addr       : redirect target
//     o_imem_req        : request valid
//     o_imem_addr       : request address
//     i_imem_gnt        : request accepted this cycle
//     i_imem_rvalid     : in-order response valid
//     i_imem_rdata      : response instruction
//     o_valid, i_ready  : decoder handshake on the queue head
//     o_instr, o_pc     : head instruction and its PC
//     o_next_pc         : head PC + 4
//     o_tag             : head pipeline tag
//     o_count           : number of buffered entries
//
//   Credit scheme: a request is issued only while buffered + outstanding
//   is below DEPTH. Every response therefore has a free slot when it
//   arrives.
// ----------------------------------------------------------------------------
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter int              TAG_W    = DEF_TAG_W,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_jump,
    input  logic [XLEN-1:0]         i_jump_addr,
    output logic                    o_imem_req,
    output logic [XLEN-1:0]         o_imem_addr,
    input  logic                    i_imem_gnt,
    input  logic                    i_imem_rvalid,
    input  logic [XLEN-1:0]         i_imem_rdata,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [XLEN-1:0]         o_instr,
    output logic [XLEN-1:0]         o_pc,
    output logic [XLEN-1:0]         o_next_pc,
    output logic [TAG_W-1:0]        o_tag,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int              CW           = $clog2(DEPTH) + 1;
    localparam int              EW           = entry_width(XLEN, TAG_W);
    localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP         = XLEN'(PC_STEP);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_q, drop_d;

    logic [CW-1:0]    count;
    logic [EW-1:0]    head;
    logic [EW-1:0]    push_data;
    logic [CW:0]      credit_sum;
    logic             grant;
    logic             rsp;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  head_pc;

    // ------------------------------------------------------------------
    // Issue: decoded from registered state only, so a grant this cycle
    // cannot feed back into the request of the same cycle.
    // ------------------------------------------------------------------
    assign credit_sum  = {1'b0, count} + {1'b0, outstanding_q};
    assign o_imem_req  = !i_rst && (credit_sum < CREDIT_LIMIT);
    assign o_imem_addr = fetch_pc_q;
    assign grant       = o_imem_req && i_imem_gnt;

    // A response with nothing outstanding cannot belong to us, for example
    // a stale beat after a reset, so it is ignored.
    assign rsp  = i_imem_rvalid && (outstanding_q != '0);

    // A jump overrides both ends of the queue in its own cycle.
    assign push = rsp && (drop_q == '0) && !i_jump;
    assign pop  = o_valid && i_ready && !i_jump;

    assign push_data = {i_imem_rdata, resp_pc_q, tag_q};

    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
        fetch_pc_d    = grant ? (fetch_pc_q + STEP) : fetch_pc_q;
        resp_pc_d     = push ? (resp_pc_q + STEP) : resp_pc_q;
        tag_d         = tag_q;
        drop_d        = (rsp && (drop_q != '0)) ? (drop_q - CW'(1)) : drop_q;
        if (i_jump) begin
            fetch_pc_d = i_jump_addr;
            resp_pc_d  = i_jump_addr;
            tag_d      = tag_q + TAG_W'(1);
            // Every request still in flight after this edge belongs to
            // the old stream. That includes one granted now and excludes
            // a response returning now. The drop count therefore becomes
            // exactly the new outstanding count. Earlier pending drops are
            // already part of outstanding_q, so a second jump does not
            // count them twice, and drop can never exceed outstanding.
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            tag_q         <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry buffer
    // ------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (pop),
        .i_flush (i_jump),
        .o_head  (head),
        .o_count (count)
    );

    // Head fields read as zero while the queue is empty. This keeps the
    // decoder-facing bus clean after reset and after a flush.
    assign o_valid   = (count != '0);
    assign o_count   = count;
    assign head_pc   = head[TAG_W +: XLEN];
    assign o_instr   = o_valid ? head[EW-1 -: XLEN] : '0;
    assign o_pc      = o_valid ? head_pc : '0;
    assign o_next_pc = o_valid ? (head_pc + STEP) : '0;
    assign o_tag     = o_valid ? head[TAG_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
    import fetch_prefetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic              clk;
    logic              i_rst;
    logic              i_jump;
    logic [XLEN-1:0]   i_jump_addr;
    logic              o_imem_req;
    logic [XLEN-1:0]   o_imem_addr;
    logic              i_imem_gnt;
    logic              i_imem_rvalid;
    logic [XLEN-1:0]   i_imem_rdata;
    logic              o_valid;
    logic              i_ready;
    logic [XLEN-1:0]   o_instr;
    logic [XLEN-1:0]   o_pc;
    logic [XLEN-1:0]   o_next_pc;
    logic [TAG_W-1:0]  o_tag;
    logic [2:0]        o_count;

    fetch_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .RESET_PC(32'h0)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_jump(i_jump), .i_jump_addr(i_jump_addr),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_next_pc(o_next_pc), .o_tag(o_tag), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests granted but not yet answered, tagged with the jump epoch
    // that was current when they were granted.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    typedef struct {
        int cycles;
        int gnt_pct;
        int rsp_pct;
        int rdy_pct;
        int jmp_pct;
        bit drain_ready;
        int exp_count;
        bit exp_req;
    } row_t;

    req_t         pend[$];
    fetch_entry_t sb[$];
    logic [31:0]  m_fetch;
    int           m_epoch;
    int           n_grants;
    int           tests;
    int           fails;
    row_t         rows[5];

    function automatic logic [31:0] instr_of(input logic [31:0] a, input int e);
        return a ^ 32'h1357_9bdf ^ (32'(e) << 20);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: check the outputs against the model, drive the
    // inputs, advance the model, and step past the next rising edge.
    task automatic cycle(input bit gnt, input bit rv, input bit rdy, input bit jmp,
                         input logic [31:0] jaddr);
        fetch_entry_t e;
        req_t         p;
        bit           g;
        chk("count", 64'(o_count), 64'(sb.size()));
        chk("valid", 64'(o_valid), 64'(sb.size() != 0));
        chk("req", 64'(o_imem_req), 64'((sb.size() + pend.size()) < DEPTH));
        if (o_imem_req) chk("addr", 64'(o_imem_addr), 64'(m_fetch));
        if (o_valid && sb.size() != 0) begin
            chk("head_instr", 64'(o_instr), 64'(sb[0].instr));
            chk("head_pc", 64'(o_pc), 64'(sb[0].pc));
            chk("head_next_pc", 64'(o_next_pc), 64'(sb[0].pc + 32'd4));
            chk("head_tag", 64'(o_tag), 64'(sb[0].tag));
        end
        i_imem_gnt    = gnt;
        i_imem_rvalid = rv;
        i_imem_rdata  = (rv && pend.size() != 0) ? instr_of(pend[0].addr, pend[0].epoch)
                                                 : 32'($urandom);
        i_ready       = rdy;
        i_jump        = jmp;
        i_jump_addr   = jaddr;
        g = o_imem_req && gnt;
        if (o_valid && rdy && !jmp && sb.size() != 0) begin
            e = sb.pop_front();
            $display("[TB] pop pc=%08h tag=%0d instr=%08h", e.pc, e.tag, e.instr);
        end
        if (rv && pend.size() != 0) begin
            p = pend.pop_front();
            if (!jmp && p.epoch == m_epoch) begin
                e.instr = instr_of(p.addr, p.epoch);
                e.pc    = p.addr;
                e.tag   = 4'(p.epoch);
                sb.push_back(e);
            end
        end
        if (g) begin
            p.addr  = m_fetch;
            p.epoch = m_epoch;
            pend.push_back(p);
            m_fetch = m_fetch + 32'd4;
            n_grants++;
        end
        if (jmp) begin
            sb.delete();
            m_epoch++;
            m_fetch = jaddr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1; i_jump = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_req", 64'(o_imem_req), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        chk("rst_next_pc", 64'(o_next_pc), 64'd0);
        chk("rst_tag", 64'(o_tag), 64'd0);
        sb.delete();
        pend.delete();
        m_fetch = 32'h0;
        m_epoch = 0;
        i_rst = 1'b0;
        #1;
    endtask

    task automatic stream(input int n);
        repeat (n) cycle(1'b1, pend.size() != 0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected run to end first");
        $fatal(1);
    end

    initial begin
        int g0;
        tests = 0; fails = 0; n_grants = 0;
        i_rst = 1'b1; i_jump = 1'b0; i_jump_addr = '0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_ready = 1'b0;
        m_fetch = 0; m_epoch = 0;

        rows[0] = '{40, 100, 100, 100, 0,  1'b1, 0, 1'b1};
        rows[1] = '{40, 70,  60,  50,  0,  1'b0, 4, 1'b0};
        rows[2] = '{60, 80,  70,  60,  10, 1'b1, 0, 1'b1};
        rows[3] = '{60, 100, 100, 30,  25, 1'b0, 4, 1'b0};
        rows[4] = '{40, 50,  50,  100, 40, 1'b1, 0, 1'b1};

        // 1. Reset, then the first request goes to address 0.
        do_reset(2);
        chk("t1_req", 64'(o_imem_req), 64'd1);
        chk("t1_addr", 64'(o_imem_addr), 64'd0);
        // A response with nothing outstanding must be ignored.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t1_stray_rsp", 64'(o_count), 64'd0);

        // 2. Streaming: one entry per cycle after the warm-up.
        stream(4);
        for (int i = 0; i < 12; i++) begin
            chk("t2_stream_valid", 64'(o_valid), 64'd1);
            stream(1);
        end

        // 3. Backpressure: only DEPTH requests, then exactly one per pop.
        do_reset(1);
        g0 = n_grants;
        repeat (8) cycle(1'b1, pend.size() != 0, 1'b0, 1'b0, 32'h0);
        chk("t3_grants", 64'(n_grants - g0), 64'd4);
        chk("t3_count", 64'(o_count), 64'd4);
        chk("t3_req", 64'(o_imem_req), 64'd0);
        g0 = n_grants;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (6) cycle(1'b1, pend.size() != 0, 1'b0, 1'b0, 32'h0);
        chk("t3_one_more", 64'(n_grants - g0), 64'd1);

        // 4. Jump with 2 buffered and 2 in flight.
        do_reset(1);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4_pre_count", 64'(o_count), 64'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        chk("t4_flush", 64'(o_count), 64'd0);
        chk("t4_jump_addr", 64'(o_imem_addr), 64'h100);
        repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_dropped", 64'(o_count), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_first_valid", 64'(o_valid), 64'd1);
        chk("t4_first_pc", 64'(o_pc), 64'h100);
        chk("t4_first_tag", 64'(o_tag), 64'd1);

        // 5. Tag wrap over 16 jumps.
        do_reset(1);
        for (int j = 1; j <= 16; j++) begin
            cycle(1'b1, pend.size() != 0, 1'b1, 1'b1, 32'h200 + 32'(j) * 32'h40);
            for (int k = 0; k < 8 && !o_valid; k++) stream(1);
            chk("t5_valid", 64'(o_valid), 64'd1);
            chk("t5_tag", 64'(o_tag), 64'(j % 16));
        end
        stream(6);

        // 6. count = DEPTH-1 with one outstanding, push and pop together.
        do_reset(1);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6_pre_count", 64'(o_count), 64'd3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t6_count_same", 64'(o_count), 64'd3);
        repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        // Reset in the middle of a stream.
        stream(5);
        do_reset(1);
        stream(8);

        // Table rows: random traffic, then a deterministic drain.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < rows[r].cycles; c++) begin
                cycle($urandom_range(99) < 32'(rows[r].gnt_pct),
                      (pend.size() != 0) && ($urandom_range(99) < 32'(rows[r].rsp_pct)),
                      $urandom_range(99) < 32'(rows[r].rdy_pct),
                      $urandom_range(99) < 32'(rows[r].jmp_pct),
                      $urandom & 32'hffff_fffc);
            end
            repeat (12) cycle(!rows[r].drain_ready, pend.size() != 0, rows[r].drain_ready,
                              1'b0, 32'h0);
            chk("row_end_count", 64'(o_count), 64'(rows[r].exp_count));
            chk("row_end_req", 64'(o_imem_req), 64'(rows[r].exp_req));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
